// File: rtl/q_argmax.sv
// -----------------------------------------------------------------------------
// q_argmax
//
// Greedy action selector. Takes a serial stream of fp16 Q-values, one per
// action, and after NUM_ACT values reports the index and value of the largest
// one.
//
// Values are ordered by mapping each fp16 word onto an unsigned key. The
// mapping is monotonic: -inf is lowest, -0 sorts below +0, and +inf is highest.
//
// NaN samples never win against a real number. The first sample of a set
// always seeds the running best, even if it is NaN. A later non-NaN sample
// replaces a NaN best. So an all-NaN set reports action 0 and the first value.
//
// Optional build macro: EPSILON_GREEDY_EN
//   When this macro is defined, a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1)
//   steps every cycle. When its low byte is below EPS, the decision takes a
//   random action index instead of the greedy one, and explore is set.
//   qmax always reports the greedy maximum.
//   When the macro is not defined, explore is constant 0.
//
// Ports
//   clk      clock
//   rst      asynchronous reset, active-high
//   ivalid   Q-value valid; one sample is taken per cycle it is high
//   in       Q-value (fp16: sign[15], exp[14:10], mant[9:0])
//   flush    synchronous abort of the partial set; wins over ivalid
//   ovalid   one-cycle pulse: a decision is ready
//   action   selected action index, held until the next decision
//   qmax     greedy maximum of the set, held until the next decision
//   explore  1 when action was chosen at random, held with action
//   busy     1 while 1..NUM_ACT-1 samples of the current set are taken
// -----------------------------------------------------------------------------
module q_argmax #(
  parameter int          WIDTH     = 16,
  parameter int          NUM_ACT   = 4,
  parameter int          IDX_W     = 2,
  parameter logic [7:0]  EPS       = 8'd26,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ivalid,
  input  logic [WIDTH-1:0] in,
  input  logic             flush,
  output logic             ovalid,
  output logic [IDX_W-1:0] action,
  output logic [WIDTH-1:0] qmax,
  output logic             explore,
  output logic             busy
);

  localparam logic [WIDTH-1:0] SIGN_BIT = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ACT - 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] cnt;
  logic [WIDTH-1:0] best_key;
  logic [IDX_W-1:0] best_idx;
  logic             best_nan;

  // Sample classification and the running comparison.
  logic [WIDTH-1:0] key;
  logic             is_nan;
  logic             take;
  logic             last;
  logic [WIDTH-1:0] win_key;
  logic [IDX_W-1:0] win_idx;
  logic [WIDTH-1:0] win_val;

  // Exploration choice (constant when the LFSR is not built).
  logic             pick;
  logic [IDX_W-1:0] pick_idx;

  // NOTE: combinational blocks assign every output first so that no path
  // leaves a signal unassigned and a latch cannot be inferred.
  always_comb begin
    key     = in[WIDTH-1] ? ~in : (in ^ SIGN_BIT);
    is_nan  = (in[14:10] == 5'h1F) && (in[9:0] != 10'd0);
    last    = (cnt == LAST_IDX);
    // A set always restarts at cnt==0. After that, a real number displaces
    // either a NaN seed or a strictly smaller key. Ties keep the older index.
    take    = (cnt == '0) || (!is_nan && (best_nan || (key > best_key)));
    win_key = take ? key : best_key;
    win_idx = take ? cnt : best_idx;
    // The key mapping can be inverted. A set MSB means the input was positive.
    win_val = win_key[WIDTH-1] ? (win_key ^ SIGN_BIT) : ~win_key;
  end

`ifdef EPSILON_GREEDY_EN
  logic [15:0]      lfsr;
  logic [IDX_W-1:0] rand_idx;

  // Right-shifting Fibonacci form. The taps at bits 0, 2, 3 and 5 realise
  // x^16+x^14+x^13+x^11+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
  end

  assign rand_idx = lfsr[IDX_W+7:8];
  assign pick     = (lfsr[7:0] < EPS) && (32'(rand_idx) < NUM_ACT);
  assign pick_idx = rand_idx;
`else
  logic unused_cfg;

  assign unused_cfg = ^{EPS, LFSR_SEED};
  assign pick       = 1'b0;
  assign pick_idx   = '0;
`endif

  // NOTE: all sequential state uses non-blocking assignments. Every register
  // then samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      best_key <= '0;
      best_idx <= '0;
      best_nan <= 1'b0;
      ovalid   <= 1'b0;
      action   <= '0;
      qmax     <= '0;
      explore  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      ovalid <= 1'b0;
      if (flush) begin
        // Drop the partial set and any sample offered in this cycle.
        // Results of the previous decision stay on the outputs.
        state <= IDLE;
        cnt   <= '0;
        busy  <= 1'b0;
      end else if (ivalid) begin
        if (take) begin
          best_key <= key;
          best_idx <= cnt;
          best_nan <= is_nan;
        end
        if (last) begin
          state   <= DONE;
          cnt     <= '0;
          busy    <= 1'b0;
          ovalid  <= 1'b1;
          qmax    <= win_val;
          action  <= pick ? pick_idx : win_idx;
          explore <= pick;
        end else begin
          state <= ACC;
          cnt   <= cnt + 1'b1;
          busy  <= 1'b1;
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_q_argmax.sv
// -----------------------------------------------------------------------------
// tb_q_argmax
//
// Self-checking bench for q_argmax with NUM_ACT=4.
//
// The driving code pushes the expected decision for each complete set into a
// queue. A monitor pops that entry on every ovalid pulse and compares it with
// the outputs. Expected values come from a reference ordering of fp16 values,
// written independently of the DUT's key mapping.
//
// When EPSILON_GREEDY_EN is defined, the DUT is built with EPS=255. A reference
// LFSR then predicts which decisions explore.
// -----------------------------------------------------------------------------
module tb_q_argmax;

  localparam int NA = 4;
`ifdef EPSILON_GREEDY_EN
  localparam logic [7:0] EPS_TB = 8'd255;
`else
  localparam logic [7:0] EPS_TB = 8'd26;
`endif
  localparam logic [15:0] SEED_TB = 16'hACE1;

  typedef struct packed {
    logic [1:0]  action;
    logic [15:0] qmax;
  } exp_t;

  typedef logic [15:0] set_t [NA];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ivalid = 1'b0;
  logic [15:0] in = '0;
  logic        flush = 1'b0;
  logic        ovalid;
  logic [1:0]  action;
  logic [15:0] qmax;
  logic        explore;
  logic        busy;

  int   vectors = 0;
  int   miscompares = 0;
  int   pulses = 0;
  int   explore_cnt = 0;
  int   act_hist [NA];
  exp_t sb [$];
  exp_t mon_e;
  logic [1:0]  last_action = '0;
  logic [15:0] last_qmax = '0;
  logic [15:0] mlfsr;
  logic [15:0] mlfsr_prev = '0;

  q_argmax #(
    .WIDTH(16), .NUM_ACT(NA), .IDX_W(2), .EPS(EPS_TB), .LFSR_SEED(SEED_TB)
  ) dut (
    .clk(clk), .rst(rst), .ivalid(ivalid), .in(in), .flush(flush),
    .ovalid(ovalid), .action(action), .qmax(qmax), .explore(explore), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic nan16(input logic [15:0] v);
    return (v[14:10] == 5'h1F) && (v[9:0] != 0);
  endfunction

  // Sign-magnitude rank: every negative value sits below 0x8000, every
  // positive value sits at or above it.
  function automatic logic [15:0] rank16(input logic [15:0] v);
    return v[15] ? (16'h7FFF - {1'b0, v[14:0]}) : (16'h8000 + {1'b0, v[14:0]});
  endfunction

  function automatic exp_t model(input set_t s);
    exp_t        r;
    logic        found;
    logic [15:0] br;
    r.action = 2'd0;
    r.qmax   = s[0];
    found    = 1'b0;
    br       = '0;
    for (int i = 0; i < NA; i++) begin
      if (!nan16(s[i]) && (!found || rank16(s[i]) > br)) begin
        found    = 1'b1;
        br       = rank16(s[i]);
        r.action = 2'(i);
        r.qmax   = s[i];
      end
    end
    return r;
  endfunction

  // Reference LFSR. mlfsr_prev holds the value used at the most recent edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mlfsr <= SEED_TB;
    end else begin
      mlfsr_prev <= mlfsr;
      mlfsr      <= (mlfsr >> 1) | 16'((mlfsr[0] ^ mlfsr[2] ^ mlfsr[3] ^ mlfsr[5]) << 15);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && ovalid) begin
      pulses++;
      if (sb.size() == 0) begin
        check("spurious_ovalid", 32'd1, 32'd0);
      end else begin
        logic       exp_explore;
        logic [1:0] exp_action;
        mon_e       = sb.pop_front();
        exp_explore = 1'b0;
        exp_action  = mon_e.action;
`ifdef EPSILON_GREEDY_EN
        exp_explore = (mlfsr_prev[7:0] < EPS_TB) && (32'(mlfsr_prev[9:8]) < NA);
        if (exp_explore) exp_action = mlfsr_prev[9:8];
`endif
        check("action",  32'(action),  32'(exp_action));
        check("qmax",    32'(qmax),    32'(mon_e.qmax));
        check("explore", 32'(explore), 32'(exp_explore));
        last_action = exp_action;
        last_qmax   = mon_e.qmax;
        if (explore) explore_cnt++;
        act_hist[action]++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_set(input set_t s, input int max_gap);
    for (int i = 0; i < NA; i++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) begin
        @(negedge clk);
        ivalid = 1'b0;
      end
      @(negedge clk);
      ivalid = 1'b1;
      in     = s[i];
      if (i == NA - 1) sb.push_back(model(s));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ivalid = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(negedge clk);
      ivalid = 1'b0;
      t++;
    end
    check("drain_queue_empty", 32'(sb.size()), 32'd0);
  endtask

  function automatic logic [15:0] rand_q();
    case ($urandom_range(7, 0))
      0:       return 16'h7E00;
      1:       return 16'h8000;
      2:       return 16'h0000;
      3:       return 16'hFC00;
      default: return 16'($urandom);
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    set_t s;
    int   p0;
    for (int i = 0; i < NA; i++) act_hist[i] = 0;

    repeat (3) @(negedge clk);
    check("rst_ovalid",  32'(ovalid),  32'd0);
    check("rst_action",  32'(action),  32'd0);
    check("rst_qmax",    32'(qmax),    32'd0);
    check("rst_explore", 32'(explore), 32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    rst = 1'b0;
    idle(2);

    // Mixed signs; ovalid exactly one cycle after the 4th sample.
    s = '{16'h3C00, 16'h4000, 16'hC000, 16'h3800};
    send_set(s, 0);
    @(negedge clk);
    ivalid = 1'b0;
    check("t1_latency_ovalid", 32'(ovalid), 32'd1);
    check("t1_busy_after",     32'(busy),   32'd0);
    @(negedge clk);
    check("t1_ovalid_1cycle",  32'(ovalid), 32'd0);
    drain();

    // All negative with a tie: lowest index wins.
    s = '{16'hC200, 16'hBC00, 16'hC000, 16'hBC00};
    send_set(s, 0);
    drain();

    // NaNs mixed in, then an all-NaN set.
    s = '{16'h7E00, 16'h3C00, 16'h7C01, 16'hFC00};
    send_set(s, 0);
    s = '{16'h7E00, 16'h7E00, 16'h7E00, 16'h7E00};
    send_set(s, 0);
    drain();

    // -0 versus +0, and +inf versus -inf.
    s = '{16'h8000, 16'h0000, 16'h8000, 16'h0000};
    send_set(s, 1);
    s = '{16'hFC00, 16'h7BFF, 16'h7C00, 16'hFC00};
    send_set(s, 1);
    drain();

    // Two sets back to back with random gaps inside each set.
    p0 = pulses;
    for (int i = 0; i < NA; i++) s[i] = rand_q();
    send_set(s, 3);
    for (int i = 0; i < NA; i++) s[i] = rand_q();
    send_set(s, 3);
    drain();
    check("t4_two_pulses", 32'(pulses - p0), 32'd2);

    // flush after two samples; the sample offered with flush is dropped.
    @(negedge clk); ivalid = 1'b1; in = 16'h5000;
    @(negedge clk); ivalid = 1'b1; in = 16'h6000;
    @(negedge clk);
    check("t5_busy_mid_set", 32'(busy), 32'd1);
    ivalid = 1'b1; in = 16'h7BFF; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; ivalid = 1'b0;
    check("t5_busy_flushed",   32'(busy),   32'd0);
    check("t5_action_held",    32'(action), 32'(last_action));
    check("t5_qmax_held",      32'(qmax),   32'(last_qmax));
    check("t5_no_ovalid",      32'(ovalid), 32'd0);
    s = '{16'h0000, 16'h8000, 16'h3C00, 16'h3C00};
    send_set(s, 0);
    drain();

    // Reset after three samples: no decision, outputs cleared.
    p0 = pulses;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); ivalid = 1'b1; in = 16'h4400 + 16'(i);
    end
    @(negedge clk);
    ivalid = 1'b0;
    rst = 1'b1;
    #1;
    check("t5r_ovalid",  32'(ovalid),  32'd0);
    check("t5r_action",  32'(action),  32'd0);
    check("t5r_qmax",    32'(qmax),    32'd0);
    check("t5r_explore", 32'(explore), 32'd0);
    check("t5r_busy",    32'(busy),    32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(5);
    check("t5r_no_pulse", 32'(pulses - p0), 32'd0);
    s = '{16'hB800, 16'hC400, 16'h3400, 16'h3000};
    send_set(s, 0);
    drain();

    // Random sets, mostly back to back.
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < NA; i++) s[i] = rand_q();
      send_set(s, (n % 3 == 0) ? 2 : 0);
    end
    drain();

`ifdef EPSILON_GREEDY_EN
    explore_cnt = 0;
    for (int i = 0; i < NA; i++) act_hist[i] = 0;
    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < NA; i++) s[i] = rand_q();
      send_set(s, 0);
    end
    drain();
    check("eps_rate_high", 32'(explore_cnt > 950), 32'd1);
    for (int i = 0; i < NA; i++) check("eps_spread", 32'(act_hist[i] > 100), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
